// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller. It drives per-stage stall/flush strobes for the
//   PC, IF, sub-IF, ID, EX, MEM and sub-MEM registers. It handles load-use
//   hazards, taken-branch redirects and instruction/data memory wait states.
//   The strobes are combinational from the current state and inputs. The FSM
//   state, the wait/redirect counters, the saturating stall counter and the
//   sticky data-memory timeout flag are registered.
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs1/rs2, id_uses_*    : ID-stage source operands and their use flags
//   ex_rd, ex_is_load        : EX-stage destination and load flag
//   ex_branch_taken          : EX resolved a taken branch/jump
//   imem_ready               : instruction fetch data valid this cycle
//   dmem_req, dmem_ready     : MEM-stage data access and its completion
//   stall_*, flush_*         : per-stage hold / bubble strobes
//   state_o                  : 0 RUN, 1 DMEM_WAIT, 2 IMEM_WAIT, 3 REDIRECT
//   stall_cnt                : saturating count of cycles with stall_pc=1
//   dmem_timeout             : sticky data-memory timeout error
module hazard_ctrl_unit #(
   parameter int REDIRECT_LEN = 1,
   parameter int DMEM_TIMEOUT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             stall_pc,
   output logic             stall_if,
   output logic             stall_sub_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_if,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             flush_mem,
   output logic             flush_sub_mem,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             dmem_timeout
);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DMEM  = 2'd1;
   localparam logic [1:0] S_IMEM  = 2'd2;
   localparam logic [1:0] S_REDIR = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [3:0]       redir_cnt_q, redir_cnt_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic dstall;
   logic timeout_hit;
   logic full_stall;

   assign load_use = ex_is_load & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign dstall   = dmem_req & ~dmem_ready;

   // The wait counter already holds the number of stalled cycles served, so
   // reaching the limit with the access still pending aborts this cycle.
   assign timeout_hit = (state_q == S_DMEM) & dstall &
                        (wait_cnt_q >= 16'(DMEM_TIMEOUT));
   assign full_stall  = dstall & ~timeout_hit;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         redir_cnt_q <= 4'd0;
         wait_cnt_q  <= 16'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         redir_cnt_q <= redir_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d     = state_q;
      redir_cnt_d = redir_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      if (full_stall) begin
         state_d     = S_DMEM;
         redir_cnt_d = 4'd0;
         wait_cnt_d  = (state_q == S_DMEM) ? wait_cnt_q + 16'd1 : 16'd1;
      end else begin
         case (state_q)
            S_DMEM: begin
               // Either the access completed or it timed out; a branch seen
               // here is picked up again once back in RUN.
               state_d    = S_RUN;
               wait_cnt_d = 16'd0;
               if (timeout_hit) timeout_d = 1'b1;
            end
            S_RUN, S_IMEM: begin
               if (ex_branch_taken) begin
                  state_d     = S_REDIR;
                  redir_cnt_d = 4'(REDIRECT_LEN);
               end else if ((state_q == S_RUN) && load_use) begin
                  state_d = S_RUN;
               end else if (!imem_ready) begin
                  state_d = S_IMEM;
               end else begin
                  state_d = S_RUN;
               end
            end
            default: begin // S_REDIR
               if (ex_branch_taken) begin
                  redir_cnt_d = 4'(REDIRECT_LEN);
               end else begin
                  redir_cnt_d = (redir_cnt_q == 4'd0) ? 4'd0 : redir_cnt_q - 4'd1;
                  if (redir_cnt_q <= 4'd1) state_d = S_RUN;
               end
            end
         endcase
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Output logic
   always_comb begin
      stall_pc      = 1'b0;
      stall_if      = 1'b0;
      stall_sub_if  = 1'b0;
      stall_id      = 1'b0;
      stall_ex      = 1'b0;
      stall_mem     = 1'b0;
      flush_if      = 1'b0;
      flush_id      = 1'b0;
      flush_ex      = 1'b0;
      flush_mem     = 1'b0;
      flush_sub_mem = 1'b0;
      if (rst) begin
         // Bubble every stage while reset is held.
         flush_if      = 1'b1;
         flush_id      = 1'b1;
         flush_ex      = 1'b1;
         flush_mem     = 1'b1;
         flush_sub_mem = 1'b1;
      end else if (full_stall) begin
         stall_pc      = 1'b1;
         stall_if      = 1'b1;
         stall_sub_if  = 1'b1;
         stall_id      = 1'b1;
         stall_ex      = 1'b1;
         stall_mem     = 1'b1;
         flush_sub_mem = 1'b1;
      end else begin
         case (state_q)
            S_DMEM: begin
               if (timeout_hit) flush_mem = 1'b1;
            end
            S_RUN, S_IMEM: begin
               if (ex_branch_taken) begin
                  flush_if = 1'b1;
                  flush_id = 1'b1;
               end else if ((state_q == S_RUN) && load_use) begin
                  stall_pc     = 1'b1;
                  stall_if     = 1'b1;
                  stall_sub_if = 1'b1;
                  stall_id     = 1'b1;
                  flush_ex     = 1'b1;
               end else if (!imem_ready) begin
                  stall_pc     = 1'b1;
                  stall_sub_if = 1'b1;
                  flush_if     = 1'b1;
               end
            end
            default: begin // S_REDIR
               flush_if = 1'b1;
               if (ex_branch_taken) flush_id = 1'b1;
            end
         endcase
      end
   end

   assign state_o      = state_q;
   assign stall_cnt    = stall_cnt_q;
   assign dmem_timeout = timeout_q;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline control unit that generates the stall_* and flush_* vectors consumed directly by the pipeline register stages (PC, IF, sub-IF, ID, EX, MEM, sub-MEM). It detects load-use hazards, taken-branch redirects, and instruction/data memory wait states. A registered FSM sequences multi-cycle waits and redirect bubbles. It also keeps a saturating stall-cycle counter and a sticky data-memory timeout flag for the verification environment.

Parameters:
REDIRECT_LEN, 1, extra cycles flush_if is held after a taken branch (range 1..15)
DMEM_TIMEOUT, 255, maximum consecutive cycles spent in DMEM_WAIT before abort (range 1..65535)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX-stage destination register
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
imem_ready  in  1  instruction memory has valid data this cycle
dmem_req  in  1  MEM stage is issuing a data access
dmem_ready  in  1  data memory completes the access this cycle
stall_pc, stall_if, stall_sub_if, stall_id, stall_ex, stall_mem  out  1 each  hold the stage register
flush_if, flush_id, flush_ex, flush_mem, flush_sub_mem  out  1 each  insert a bubble in the stage register
state_o  out  2  FSM state: 0 RUN, 1 DMEM_WAIT, 2 IMEM_WAIT, 3 REDIRECT
stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1
dmem_timeout  out  1  sticky timeout error

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, redirect counter=0, wait counter=0, stall_cnt=0, dmem_timeout=0.
- While rst=1, outputs are: all flush_*=1 and all stall_*=0.
- Stall and flush outputs are combinational from the current state and inputs (0-cycle latency). State and counters are registered.
- load_use = ex_is_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- dstall = dmem_req & ~dmem_ready.
- Defaults: all stall_* and flush_* outputs are 0.
- Priority in every state: dstall, then ex_branch_taken, then load_use, then ~imem_ready. Only the highest-priority condition applies in a cycle.
- dstall (any state): all six stall_* =1 and flush_sub_mem=1. Next state is DMEM_WAIT; wait counter is cleared to 1.
- DMEM_WAIT:
  - While dstall: full stall continues and the wait counter increments.
  - If the counter reaches DMEM_TIMEOUT while still dstall: the next cycle outputs flush_mem=1 and no stalls, dmem_timeout is set (sticky until rst), and state returns to RUN.
  - When dmem_ready=1: no stalls that cycle; next state is RUN.
  - ex_branch_taken is ignored while EX is stalled; it is re-evaluated in RUN.
- ex_branch_taken (RUN, IMEM_WAIT, REDIRECT): flush_if=1 and flush_id=1. Next state is REDIRECT with the redirect counter loaded to REDIRECT_LEN.
- REDIRECT: flush_if=1 each cycle while the counter decrements; the state leaves for RUN after the cycle where counter==1. A new ex_branch_taken in REDIRECT reloads the counter.
- load_use (RUN only): stall_pc, stall_if, stall_sub_if, stall_id =1 and flush_ex=1. The state stays RUN, so exactly one bubble is inserted per hazard cycle.
- ~imem_ready (RUN or IMEM_WAIT): stall_pc=1, stall_sub_if=1, flush_if=1. State is IMEM_WAIT; it returns to RUN in the cycle imem_ready=1, with no stall in that cycle.
- stall_cnt increments on every non-reset cycle with stall_pc=1 and saturates at all-ones (no wrap).
- Reset asserted mid-wait or mid-redirect aborts immediately to reset state; no partial outputs persist.

Test Plan:
1. Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> stall_pc/if/sub_if/id=1 and flush_ex=1 for exactly 1 cycle; state_o=0; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
2. Data wait: dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 -> full stall plus flush_sub_mem for 3 cycles; state_o=1 for cycles 2–4; no stall on the ready cycle; stall_cnt=3.
3. Branch with REDIRECT_LEN=2: ex_branch_taken pulse -> flush_if and flush_id=1 on cycle 0; flush_if only on cycles 1–2; state_o=3 then 0. Simultaneous load_use on cycle 0 -> no stall (branch wins).
4. Priority: dstall, ex_branch_taken and load_use all asserted together -> full stall only, state DMEM_WAIT; the branch flush occurs on the first RUN cycle after dmem_ready.
5. Timeout with DMEM_TIMEOUT=4: dmem_ready held 0 -> 4 stall cycles, then flush_mem=1 and dmem_timeout=1 (stays 1); state_o=0. A subsequent rst clears dmem_timeout.
6. Saturation/reset with CNT_W=4: hold imem_ready=0 for 20 cycles -> stall_cnt stops at 15. Assert rst mid-IMEM_WAIT -> all flushes=1, stalls=0, then state_o=0 and stall_cnt=0.
